// File: rtl/mmio_test_monitor.sv
// rtl/mmio_test_monitor.sv - MMIO test monitor: status decode, log FIFO, cycle counter, optional watchdog
// Optional watchdog enabled by defining MMIO_MON_WATCHDOG_EN.
module mmio_test_monitor #(
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter logic [31:0] PASS_CODE      = 32'd55,
  parameter int          NUM_CH         = 4,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          CNT_W          = 32,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  input  logic             log_ready,
  output logic             log_valid,
  output logic [CH_W-1:0]  log_chan,
  output logic [31:0]      log_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      fail_code,
  output logic             timeout,
  output logic             overflow,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LOG_BASE = BASE_ADDR + 32'h10;
`ifdef MMIO_MON_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_RUN, S_DONE, S_TMO} state_t;
  state_t state, state_n;

  logic            wr_ok, status_hit, log_hit, at_limit, expire;
  logic [29:0]     log_word;
  logic [CH_W-1:0] log_ch;

  assign wr_ok      = MemWrite && (DataAdr[1:0] == 2'b00);
  assign status_hit = wr_ok && (DataAdr == BASE_ADDR + 32'hC);
  // Word index relative to LOG[0]; addresses below the window wrap to huge values.
  assign log_word   = DataAdr[31:2] - LOG_BASE[31:2];
  assign log_hit    = wr_ok && (log_word < 30'(NUM_CH));
  assign log_ch     = log_word[CH_W-1:0];
  assign at_limit   = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign expire     = WD_EN && at_limit;

  always_comb begin
    state_n = state;
    case (state)
      S_RUN: begin
        if (status_hit)  state_n = S_DONE;
        else if (expire) state_n = S_TMO;
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_n;
  end

  logic [CH_W-1:0] mem_ch   [FIFO_DEPTH];
  logic [31:0]     mem_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, push_ok, timeout_q;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = log_valid && log_ready;
  assign push_ok = log_hit && (!full || pop);

  assign log_valid = (count != '0);
  assign log_chan  = log_valid ? mem_ch[rd_ptr]   : '0;
  assign log_data  = log_valid ? mem_data[rd_ptr] : '0;
  assign timeout   = WD_EN && timeout_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ch[wr_ptr]   <= log_ch;
      mem_data[wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= '0;
      timeout_q   <= 1'b0;
      overflow    <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (state == S_RUN && status_hit) begin
        done <= 1'b1;
        if (WriteData == PASS_CODE) begin
          pass <= 1'b1;
        end else begin
          fail      <= 1'b1;
          fail_code <= WriteData;
        end
      end else if (state == S_RUN && expire) begin
        timeout_q <= 1'b1;
      end
      // The transition edge itself does not count, so the count freezes at the exit value.
      if (state == S_RUN && state_n == S_RUN && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (log_hit && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_test_monitor.sv
// tb/tb_mmio_test_monitor.sv - directed self-checking bench for mmio_test_monitor
module tb_mmio_test_monitor;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] STATUS = BASE + 32'hC;
  localparam logic [31:0] LOG0   = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset, MemWrite, log_ready;
  logic [31:0] DataAdr, WriteData;
  logic        log_valid, done, pass, fail, timeout, overflow;
  logic [1:0]  log_chan;
  logic [31:0] log_data, fail_code, cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_test_monitor #(
    .BASE_ADDR(BASE), .PASS_CODE(32'd55), .NUM_CH(4), .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(20), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .log_ready(log_ready), .log_valid(log_valid),
    .log_chan(log_chan), .log_data(log_data), .done(done), .pass(pass),
    .fail(fail), .fail_code(fail_code), .timeout(timeout),
    .overflow(overflow), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick(1);
    MemWrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] ch, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(log_valid), 32'd1);
    chk({tag, "_chan"},  32'(log_chan), ch);
    chk({tag, "_data"},  log_data, d);
    log_ready = 1'b1;
    tick(1);
    log_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; log_ready = 1'b0;
    tick(2);
    reset = 1'b0;

    // reset state (sampled while still in reset's aftermath)
    do_reset();
    chk("rst_valid", 32'(log_valid), 0);
    chk("rst_chan", 32'(log_chan), 0);
    chk("rst_data", log_data, 0);
    chk("rst_flags", {26'd0, done, pass, fail, timeout, overflow, 1'b0}, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_cnt", cycle_count, 0);

    // pass: 3 idle edges, status on 4th edge, count frozen at 3
    tick(3);
    wr(STATUS, 32'd55);
    chk("pass_done", 32'(done), 1);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_fail", 32'(fail), 0);
    tick(2);
    chk("pass_cnt", cycle_count, 3);

    // fail then pass: first write wins
    do_reset();
    wr(STATUS, 32'd7);
    wr(STATUS, 32'd55);
    chk("fail_fail", 32'(fail), 1);
    chk("fail_pass", 32'(pass), 0);
    chk("fail_code", fail_code, 32'd7);
    chk("fail_done", 32'(done), 1);

    // overflow: 9 pushes into depth 8, then drain 8
    do_reset();
    for (int i = 0; i < 9; i++) wr(LOG0 + 32'd4, 32'hA0 + i);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 1, 32'hA0 + i);
    chk("ovf_empty", 32'(log_valid), 0);

    // push+pop on full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) wr(LOG0 + 32'd8, 32'hC0 + i);
    log_ready = 1'b1;
    wr(LOG0 + 32'd12, 32'hBB);
    log_ready = 1'b0;
    chk("fp_ovf", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) pop_chk("fp_pop", 2, 32'hC0 + i);
    pop_chk("fp_last", 3, 32'hBB);
    chk("fp_empty", 32'(log_valid), 0);

    // push while empty with ready high: entry is stored
    do_reset();
    log_ready = 1'b1;
    wr(LOG0, 32'h11);
    log_ready = 1'b0;
    pop_chk("emp_pop", 0, 32'h11);

    // watchdog
    do_reset();
    tick(19);
    chk("wd_pre_to", 32'(timeout), 0);
    chk("wd_pre_cnt", cycle_count, 19);
    tick(1);
`ifdef MMIO_MON_WATCHDOG_EN
    chk("wd_to", 32'(timeout), 1);
    chk("wd_cnt", cycle_count, 19);
    wr(STATUS, 32'd55);
    chk("wd_done", 32'(done), 0);
`else
    chk("wd_to", 32'(timeout), 0);
    chk("wd_cnt", cycle_count, 20);
    wr(STATUS, 32'd55);
    chk("wd_done", 32'(done), 1);
`endif

    // bad addresses and reset mid-fill
    do_reset();
    wr(BASE + 32'h0D, 32'd55);
    wr(LOG0 + 32'h11, 32'h5);
    wr(LOG0 + 32'd16, 32'h6);
    chk("bad_valid", 32'(log_valid), 0);
    chk("bad_done", 32'(done), 0);
    wr(LOG0, 32'h1);
    wr(LOG0, 32'h2);
    chk("mid_valid", 32'(log_valid), 1);
    reset = 1'b1;
    wr(LOG0, 32'h3);
    reset = 1'b0;
    chk("rst2_valid", 32'(log_valid), 0);
    chk("rst2_flags", {27'd0, done, pass, fail, timeout, overflow}, 0);
    chk("rst2_cnt", cycle_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
